// File: rtl/sm4_round_ctrl.sv
// sm4_round_ctrl
// Sequencing controller for an iterative SM4 core.
//   - Accepts a master-key load request, latches the key and pulses cfg
//     towards key expansion, then waits for key_ready to go low and then
//     high again. Only after that are the round keys considered valid.
//   - Accepts data-block requests while keys are valid and steps one
//     iterative round engine through ROUND_NUM rounds of ROUND_DELAY
//     cycles each, producing the round-key read address (ascending for
//     encrypt, descending for decrypt).
//   - Downstream back-pressure (out_stall) is forwarded as stall and
//     freezes the round sequencing while a block is running.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   key_req/key_mk/key_ack  master-key load handshake (key_mk = {MK0..MK3})
//   cfg, cfg_mk0..cfg_mk3   key-expansion start pulse and latched key words
//   key_ready               all round keys written (from key expansion)
//   keys_valid              round keys usable (READY or RUN)
//   blk_valid/blk_mode/blk_ready  block request handshake, mode 1 = decrypt
//   out_stall, stall        downstream hold in, forwarded hold out
//   rnd_start, rnd_step     first cycle of round 0, last cycle of a round
//   rk_addr                 round-key address for the current round
//   blk_done                one-cycle pulse after the last round
//   busy                    controller is configuring keys or running a block
module sm4_round_ctrl #(
  parameter int ROUND_NUM   = 32,
  parameter int ROUND_DELAY = 4,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_req,
  input  logic [4*WORD_WIDTH-1:0] key_mk,
  output logic                    key_ack,
  output logic                    cfg,
  output logic [WORD_WIDTH-1:0]   cfg_mk0,
  output logic [WORD_WIDTH-1:0]   cfg_mk1,
  output logic [WORD_WIDTH-1:0]   cfg_mk2,
  output logic [WORD_WIDTH-1:0]   cfg_mk3,
  input  logic                    key_ready,
  output logic                    keys_valid,
  input  logic                    blk_valid,
  input  logic                    blk_mode,
  output logic                    blk_ready,
  input  logic                    out_stall,
  output logic                    stall,
  output logic                    rnd_start,
  output logic                    rnd_step,
  output logic [ADDR_WIDTH-1:0]   rk_addr,
  output logic                    blk_done,
  output logic                    busy
);

  localparam int DLY_W = (ROUND_DELAY > 1) ? $clog2(ROUND_DELAY) : 1;
  localparam logic [DLY_W-1:0]      DLY_LAST = DLY_W'(ROUND_DELAY - 1);
  localparam logic [ADDR_WIDTH-1:0] RND_LAST = ADDR_WIDTH'(ROUND_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT_LO,
    S_WAIT_HI,
    S_READY,
    S_RUN
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic                    decrypt_reg;
  logic [ADDR_WIDTH-1:0]   rnd_cnt_reg;
  logic [DLY_W-1:0]        dly_cnt_reg;
  logic [ADDR_WIDTH-1:0]   rk_addr_reg;
  logic                    rnd_start_reg;
  logic                    blk_done_reg;
  logic [WORD_WIDTH-1:0]   mk_reg [4];

  logic load_key;
  logic blk_accept;
  logic last_round;

  // A key request is only served from IDLE or READY; during RUN it simply
  // stays pending until the block finishes.
  assign load_key   = ((state_reg == S_IDLE) || (state_reg == S_READY)) && key_req;
  assign blk_ready  = (state_reg == S_READY) && !key_req;
  assign blk_accept = blk_ready && blk_valid;
  assign rnd_step   = (state_reg == S_RUN) && !out_stall && (dly_cnt_reg == DLY_LAST);
  assign last_round = (rnd_cnt_reg == RND_LAST);

  assign key_ack    = (state_reg == S_CFG);
  assign cfg        = (state_reg == S_CFG);
  assign keys_valid = (state_reg == S_READY) || (state_reg == S_RUN);
  assign busy       = (state_reg != S_IDLE) && (state_reg != S_READY);
  assign stall      = out_stall;
  assign rnd_start  = rnd_start_reg;
  assign blk_done   = blk_done_reg;
  assign rk_addr    = rk_addr_reg;
  assign cfg_mk0    = mk_reg[0];
  assign cfg_mk1    = mk_reg[1];
  assign cfg_mk2    = mk_reg[2];
  assign cfg_mk3    = mk_reg[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (key_req) state_next = S_CFG;
      end
      S_CFG: begin
        state_next = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        // key_ready may still be high from the previous key; it must be
        // seen low once before a high level means the new keys are in.
        if (!key_ready) state_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (key_ready) state_next = S_READY;
      end
      S_READY: begin
        if (key_req) begin
          state_next = S_CFG;
        end else if (blk_valid) begin
          state_next = S_RUN;
        end else if (!key_ready) begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (rnd_step && last_round) state_next = S_READY;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Key words: MK0 sits in the most significant word of key_mk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mk_reg[i] <= '0;
    end else if (load_key) begin
      for (int i = 0; i < 4; i++) mk_reg[i] <= key_mk[(4-i)*WORD_WIDTH-1 -: WORD_WIDTH];
    end
  end

  // Round sequencing. Everything here is frozen while out_stall is high
  // inside RUN, which shifts all later events by one cycle per stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decrypt_reg   <= 1'b0;
      rnd_cnt_reg   <= '0;
      dly_cnt_reg   <= '0;
      rk_addr_reg   <= '0;
      rnd_start_reg <= 1'b0;
      blk_done_reg  <= 1'b0;
    end else begin
      rnd_start_reg <= blk_accept;
      blk_done_reg  <= rnd_step && last_round;
      if (blk_accept) begin
        decrypt_reg <= blk_mode;
        rnd_cnt_reg <= '0;
        dly_cnt_reg <= '0;
        rk_addr_reg <= blk_mode ? RND_LAST : '0;
      end else if ((state_reg == S_RUN) && !out_stall) begin
        if (rnd_step) begin
          dly_cnt_reg <= '0;
          // The address is left on the last key after the final round.
          if (!last_round) begin
            rnd_cnt_reg <= rnd_cnt_reg + 1'b1;
            rk_addr_reg <= decrypt_reg ? (rk_addr_reg - 1'b1) : (rk_addr_reg + 1'b1);
          end
        end else begin
          dly_cnt_reg <= dly_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Testbench for sm4_round_ctrl: randomized key loads and blocks checked
// every cycle against a behavioural model, plus literal latency checks.
module tb_sm4_round_ctrl;

  localparam int RN = 32;
  localparam int RD = 4;
  localparam int W  = 32;
  localparam int AW = 5;

  localparam int P_IDLE  = 0;
  localparam int P_CFG   = 1;
  localparam int P_WLO   = 2;
  localparam int P_WHI   = 3;
  localparam int P_READY = 4;
  localparam int P_RUN   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_req = 1'b0;
  logic [4*W-1:0] key_mk = '0;
  logic          key_ready = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_mode = 1'b0;
  logic          out_stall = 1'b0;

  logic          key_ack, cfg, keys_valid, blk_ready, stall;
  logic          rnd_start, rnd_step, blk_done, busy;
  logic [W-1:0]  cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3;
  logic [AW-1:0] rk_addr;

  sm4_round_ctrl #(
    .ROUND_NUM(RN), .ROUND_DELAY(RD), .WORD_WIDTH(W), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_req(key_req), .key_mk(key_mk), .key_ack(key_ack), .cfg(cfg),
    .cfg_mk0(cfg_mk0), .cfg_mk1(cfg_mk1), .cfg_mk2(cfg_mk2), .cfg_mk3(cfg_mk3),
    .key_ready(key_ready), .keys_valid(keys_valid),
    .blk_valid(blk_valid), .blk_mode(blk_mode), .blk_ready(blk_ready),
    .out_stall(out_stall), .stall(stall),
    .rnd_start(rnd_start), .rnd_step(rnd_step), .rk_addr(rk_addr),
    .blk_done(blk_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event (cycle %0d)", nm, cyc);
  endtask

  // ---------------- behavioural model ----------------
  int           m_phase = P_IDLE;
  logic         m_enc = 1'b1;
  int           m_work = 0;     // unstalled RUN cycles since the block began
  logic         m_start = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_mk = '0;

  logic          e_cfg, e_kv, e_busy, e_br, e_step, e_done_n;
  int            e_rnd;
  logic [AW-1:0] e_addr;

  // observations used by the literal checks
  int            acc_cyc = 0;
  int            done_cyc = 0;
  int            done_seen = 0;
  int            a10_cnt = 0;
  logic [AW-1:0] first_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_key_ack", 64'(key_ack), 0);
      chk("rst_cfg", 64'(cfg), 0);
      chk("rst_keys_valid", 64'(keys_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_blk_ready", 64'(blk_ready), 0);
      chk("rst_rnd_start", 64'(rnd_start), 0);
      chk("rst_rnd_step", 64'(rnd_step), 0);
      chk("rst_blk_done", 64'(blk_done), 0);
      chk("rst_rk_addr", 64'(rk_addr), 0);
      chk("rst_stall", 64'(stall), 0);
      chk128("rst_cfg_mk", {cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3}, 128'd0);
      m_phase = P_IDLE;
      m_work  = 0;
      m_start = 1'b0;
      m_done  = 1'b0;
      m_mk    = '0;
      m_enc   = 1'b1;
    end else begin
      e_cfg  = (m_phase == P_CFG);
      e_kv   = (m_phase == P_READY) || (m_phase == P_RUN);
      e_busy = !((m_phase == P_IDLE) || (m_phase == P_READY));
      e_br   = (m_phase == P_READY) && !key_req;
      e_rnd  = m_work / RD;
      e_step = (m_phase == P_RUN) && !out_stall && ((m_work % RD) == RD - 1);
      e_addr = m_enc ? AW'(e_rnd) : AW'(RN - 1 - e_rnd);

      chk("key_ack", 64'(key_ack), 64'(e_cfg));
      chk("cfg", 64'(cfg), 64'(e_cfg));
      chk("keys_valid", 64'(keys_valid), 64'(e_kv));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("blk_ready", 64'(blk_ready), 64'(e_br));
      chk("stall", 64'(stall), 64'(out_stall));
      chk("rnd_start", 64'(rnd_start), 64'(m_start));
      chk("rnd_step", 64'(rnd_step), 64'(e_step));
      chk("blk_done", 64'(blk_done), 64'(m_done));
      if (m_phase == P_RUN) chk("rk_addr", 64'(rk_addr), 64'(e_addr));
      chk128("cfg_mk", {cfg_mk0, cfg_mk1, cfg_mk2, cfg_mk3}, m_mk);

      if (blk_ready && blk_valid) begin
        acc_cyc = cyc;
        a10_cnt = 0;
      end
      if (rnd_start) first_addr = rk_addr;
      if (blk_done) begin
        done_cyc = cyc;
        done_seen++;
      end
      if (busy && keys_valid && rk_addr == AW'(10)) a10_cnt++;

      // advance the model to the next cycle
      e_done_n = e_step && (e_rnd == RN - 1);
      m_start  = e_br && blk_valid;
      case (m_phase)
        P_IDLE: if (key_req) begin m_phase = P_CFG; m_mk = key_mk; end
        P_CFG:  m_phase = P_WLO;
        P_WLO:  if (!key_ready) m_phase = P_WHI;
        P_WHI:  if (key_ready) m_phase = P_READY;
        P_READY: begin
          if (key_req) begin
            m_phase = P_CFG;
            m_mk = key_mk;
          end else if (blk_valid) begin
            m_phase = P_RUN;
            m_enc = !blk_mode;
            m_work = 0;
          end else if (!key_ready) begin
            m_phase = P_IDLE;
          end
        end
        P_RUN: begin
          if (!out_stall) m_work++;
          if (e_done_n) m_phase = P_READY;
        end
        default: m_phase = P_IDLE;
      endcase
      m_done = e_done_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input int hold_stale);
    int n;
    key_req = 1'b1;
    key_mk  = k;
    n = 0;
    while (!key_ack && n < 400) begin tick(); n++; end
    if (!key_ack) timeout("key_ack_wait");
    key_req = 1'b0;
    key_mk  = {$urandom, $urandom, $urandom, $urandom};
    repeat (hold_stale) tick();
    chk("kv_low_while_cfg", 64'(keys_valid), 0);
    key_ready = 1'b0;
    repeat ($urandom_range(2, 5)) tick();
    key_ready = 1'b1;
    tick();
    chk("kv_rise_latency", 64'(keys_valid), 1);
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n;
    n = 0;
    while (done_seen == d0 && n < limit) begin tick(); n++; end
    if (done_seen == d0) timeout("blk_done_wait");
  endtask

  // stall_mode: 0 none, 1 three cycles inside round 10, 2 random
  task automatic run_block(input logic mode, input int stall_mode);
    int n;
    int d0;
    d0 = done_seen;
    blk_mode  = mode;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 400) begin
      if (stall_mode == 2) out_stall = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    if (!blk_ready) begin
      timeout("blk_ready_wait");
      blk_valid = 1'b0;
      return;
    end
    tick();
    blk_valid = 1'b0;
    blk_mode  = 1'($urandom);
    if (stall_mode == 1) begin
      out_stall = 1'b0;
      n = 0;
      while (rk_addr != AW'(10) && n < 200) begin tick(); n++; end
      tick();
      out_stall = 1'b1;
      repeat (3) tick();
      out_stall = 1'b0;
    end
    n = 0;
    while (done_seen == d0 && n < 1000) begin
      if (stall_mode == 2) out_stall = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    out_stall = 1'b0;
    if (done_seen == d0) begin
      timeout("blk_done_wait");
      return;
    end
    chk("first_rk_addr", 64'(first_addr), mode ? 64'(RN - 1) : 0);
    if (stall_mode == 0) chk("done_latency", 64'(done_cyc - acc_cyc), 129);
    if (stall_mode == 1) begin
      chk("done_latency_stall", 64'(done_cyc - acc_cyc), 132);
      chk("addr10_hold", 64'(a10_cnt), 7);
    end
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    load_key(128'h0123456789abcdeffedcba9876543210, 0);
    chk("cfg_mk0_literal", 64'(cfg_mk0), 64'h01234567);
    chk("cfg_mk3_literal", 64'(cfg_mk3), 64'h76543210);

    run_block(1'b0, 0);
    run_block(1'b1, 0);
    run_block(1'b0, 1);

    // key request raised mid-RUN while another block is also waiting
    blk_mode  = 1'b0;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 50) begin tick(); n++; end
    tick();
    repeat (50) tick();
    done_cyc = -100;
    key_req = 1'b1;
    key_mk  = 128'h00112233445566778899aabbccddeeff;
    n = 0;
    while (!key_ack && n < 300) begin tick(); n++; end
    if (!key_ack) timeout("mid_run_key_ack");
    else chk("ack_after_done", 64'(cyc - done_cyc), 1);
    key_req = 1'b0;
    repeat (3) tick();
    chk("stale_ready_kv", 64'(keys_valid), 0);
    chk("stale_ready_busy", 64'(busy), 1);
    chk("stale_ready_blk_ready", 64'(blk_ready), 0);
    key_ready = 1'b0;
    repeat (2) tick();
    key_ready = 1'b1;
    n = 0;
    while (!(busy && keys_valid) && n < 20) begin tick(); n++; end
    if (!(busy && keys_valid)) timeout("blk_after_keys");
    d0 = done_seen;
    blk_valid = 1'b0;
    chk("cfg_mk1_after_reload", 64'(cfg_mk1), 64'h44556677);
    wait_done(d0, 400);

    // randomized traffic
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 2) == 0)
        load_key({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
      run_block(1'($urandom), 2);
    end

    // unexpected key_ready drop in READY
    key_ready = 1'b0;
    tick();
    chk("drop_keys_valid", 64'(keys_valid), 0);
    repeat (2) tick();
    load_key(128'hfedcba98765432100123456789abcdef, 0);

    // reset in the middle of a block
    blk_mode  = 1'b1;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 50) begin tick(); n++; end
    tick();
    blk_valid = 1'b0;
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_rk_addr", 64'(rk_addr), 0);
    tick();
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (150) tick();
    chk("no_done_after_reset", 64'(done_seen), 64'(d0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got no finish, expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
